// File: rtl/reg_write_decoder.sv
// -----------------------------------------------------------------------------
// reg_write_decoder
//
// Write-side companion to the register read mux. A bus write is captured on the
// clock edge where s_sel & s_wr is high. On the next edge that write is turned
// into exactly one of the following:
//   - a one-hot strobe for DATA_REG R0-R9,
//   - a one-hot strobe for INST_REG I0-I9,
//   - an update of one CONT_REG register (OP_START / INT_MASK / INTERRUPT),
//   - or a single wr_err pulse when the address is illegal.
// A bus write presented in cycle k shows its strobe in cycle k+2, together
// with wr_data.
//
// Optional feature (macro REG_WRITE_PROTECT_EN):
//   Defined:   while op_start[0] is 1, writes to I0-I9 are dropped and flagged
//              with wr_err. DATA and CTRL writes are unaffected.
//   Undefined: INST_REG writes are always allowed.
//
// Ports
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous reset, active-high
//   s_sel       in   1       bus select
//   s_wr        in   1       bus write qualifier (write accepted on s_sel & s_wr)
//   s_addr      in   ADDR_W  write address
//   s_din       in   DATA_W  write data
//   op_done     in   1       core pulse, clears op_start[0]
//   int_set     in   DATA_W  per-bit interrupt set pulses
//   wr_data     out  DATA_W  write data, valid with its strobe, held until next write
//   wr_en_data  out  10      one-hot strobe, bit n -> Rn
//   wr_en_inst  out  10      one-hot strobe, bit n -> In
//   op_start    out  DATA_W  OP_START register
//   int_mask    out  DATA_W  INT_MASK register
//   interrupt   out  DATA_W  INTERRUPT register
//   irq         out  1       registered |(interrupt & ~int_mask)
//   wr_err      out  1       one-cycle pulse on an illegal or blocked write
//   dbg_state   out  1       FSM state (0 = IDLE, 1 = STROBE)
//
// Bus handshake: there is no ready. Every cycle with s_sel & s_wr high is one
// accepted write, including cycles where the FSM is already in STROBE, so
// back-to-back writes sustain one write per clock.
// -----------------------------------------------------------------------------
module reg_write_decoder #(
  parameter int                 DATA_W    = 64,
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  BASE_DATA = 'h0100,
  parameter logic [ADDR_W-1:0]  BASE_INST = 'h0110,
  parameter logic [ADDR_W-1:0]  BASE_CTRL = 'h0120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  input  logic              op_done,
  input  logic [DATA_W-1:0] int_set,
  output logic [DATA_W-1:0] wr_data,
  output logic [9:0]        wr_en_data,
  output logic [9:0]        wr_en_inst,
  output logic [DATA_W-1:0] op_start,
  output logic [DATA_W-1:0] int_mask,
  output logic [DATA_W-1:0] interrupt,
  output logic              irq,
  output logic              wr_err,
  output logic              dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    STROBE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q,      state_d;
  logic [ADDR_W-1:0]   addr_q,       addr_d;
  logic [DATA_W-1:0]   din_q,        din_d;
  logic [DATA_W-1:0]   wr_data_q,    wr_data_d;
  logic [9:0]          wr_en_data_q, wr_en_data_d;
  logic [9:0]          wr_en_inst_q, wr_en_inst_d;
  logic [DATA_W-1:0]   op_start_q,   op_start_d;
  logic [DATA_W-1:0]   int_mask_q,   int_mask_d;
  logic [DATA_W-1:0]   interrupt_q,  interrupt_d;
  logic                irq_q,        irq_d;
  logic                wr_err_q,     wr_err_d;

  // ---------------------------------------------------------------------------
  // Decode of the captured address
  // ---------------------------------------------------------------------------
  logic                wr_accept;
  logic [ADDR_W-1:0]   off_data;
  logic [ADDR_W-1:0]   off_inst;
  logic [ADDR_W-1:0]   off_ctrl;
  logic                hit_data;
  logic                hit_inst;
  logic                hit_ctrl;
  logic                inst_blocked;
  logic                wr_op_start;
  logic                wr_int_mask;
  logic                wr_interrupt;

  assign wr_accept = s_sel & s_wr;

  // Offsets are taken with wrap-around subtraction, so an address below a
  // base becomes a large offset and falls out of range on its own.
  assign off_data = addr_q - BASE_DATA;
  assign off_inst = addr_q - BASE_INST;
  assign off_ctrl = addr_q - BASE_CTRL;

  assign hit_data = (off_data < ADDR_W'(10));
  assign hit_inst = (off_inst < ADDR_W'(10));
  assign hit_ctrl = (off_ctrl < ADDR_W'(3));

`ifdef REG_WRITE_PROTECT_EN
  // An operation in flight owns the instruction registers.
  assign inst_blocked = op_start_q[0];
`else
  assign inst_blocked = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM and capture registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    // IDLE and STROBE both take a new write; STROBE falls back to IDLE when
    // nothing new arrives.
    if (wr_accept) begin
      state_d = STROBE;
      addr_d  = s_addr;
      din_d   = s_din;
    end else begin
      state_d = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Strobe generation, done only while the FSM is in STROBE
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en_data_d = '0;
    wr_en_inst_d = '0;
    wr_err_d     = 1'b0;
    wr_op_start  = 1'b0;
    wr_int_mask  = 1'b0;
    wr_interrupt = 1'b0;
    wr_data_d    = wr_data_q;

    if (state_q == STROBE) begin
      wr_data_d = din_q;
      if (hit_data) begin
        wr_en_data_d = 10'(1) << off_data[3:0];
      end else if (hit_inst && !inst_blocked) begin
        wr_en_inst_d = 10'(1) << off_inst[3:0];
      end else if (hit_ctrl) begin
        case (off_ctrl[1:0])
          2'd0:    wr_op_start  = 1'b1;
          2'd1:    wr_int_mask  = 1'b1;
          default: wr_interrupt = 1'b1;
        endcase
      end else begin
        // Unknown address or a blocked INST write.
        wr_err_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CONT_REG registers
  // ---------------------------------------------------------------------------
  always_comb begin
    // OP_START: op_done clears bit0; a write landing in the same cycle wins.
    op_start_d = op_start_q;
    if (op_done) begin
      op_start_d[0] = 1'b0;
    end
    if (wr_op_start) begin
      op_start_d = din_q;
    end

    int_mask_d = wr_int_mask ? din_q : int_mask_q;

    // INTERRUPT: write-1-to-clear, and set is applied afterwards so it wins.
    interrupt_d = interrupt_q;
    if (wr_interrupt) begin
      interrupt_d = interrupt_d & ~din_q;
    end
    interrupt_d = interrupt_d | int_set;

    // irq follows the registers with one cycle of delay.
    irq_d = |(interrupt_q & ~int_mask_q);
  end

  // ---------------------------------------------------------------------------
  // Flops
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      din_q        <= '0;
      wr_data_q    <= '0;
      wr_en_data_q <= '0;
      wr_en_inst_q <= '0;
      op_start_q   <= '0;
      int_mask_q   <= '0;
      interrupt_q  <= '0;
      irq_q        <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      wr_data_q    <= wr_data_d;
      wr_en_data_q <= wr_en_data_d;
      wr_en_inst_q <= wr_en_inst_d;
      op_start_q   <= op_start_d;
      int_mask_q   <= int_mask_d;
      interrupt_q  <= interrupt_d;
      irq_q        <= irq_d;
      wr_err_q     <= wr_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wr_data    = wr_data_q;
  assign wr_en_data = wr_en_data_q;
  assign wr_en_inst = wr_en_inst_q;
  assign op_start   = op_start_q;
  assign int_mask   = int_mask_q;
  assign interrupt  = interrupt_q;
  assign irq        = irq_q;
  assign wr_err     = wr_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_reg_write_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for reg_write_decoder.
//
// A reference model tracks the register file from the behavioural rules. Each
// accepted write waits in a queue for one edge and is then applied. Directed
// scenarios run first, followed by a randomized run. Every cycle, all DUT
// outputs are compared against the model.
// -----------------------------------------------------------------------------
module tb_reg_write_decoder;

  localparam int          DW = 64;
  localparam int          AW = 16;
  localparam logic [15:0] BD = 16'h0100;
  localparam logic [15:0] BI = 16'h0110;
  localparam logic [15:0] BC = 16'h0120;

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          reset;
  logic          s_sel;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_din;
  logic          op_done;
  logic [DW-1:0] int_set;
  logic [DW-1:0] wr_data;
  logic [9:0]    wr_en_data;
  logic [9:0]    wr_en_inst;
  logic [DW-1:0] op_start;
  logic [DW-1:0] int_mask;
  logic [DW-1:0] interrupt;
  logic          irq;
  logic          wr_err;
  logic          dbg_state;

  always #5 clk = ~clk;

  reg_write_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .s_sel      (s_sel),
    .s_wr       (s_wr),
    .s_addr     (s_addr),
    .s_din      (s_din),
    .op_done    (op_done),
    .int_set    (int_set),
    .wr_data    (wr_data),
    .wr_en_data (wr_en_data),
    .wr_en_inst (wr_en_inst),
    .op_start   (op_start),
    .int_mask   (int_mask),
    .interrupt  (interrupt),
    .irq        (irq),
    .wr_err     (wr_err),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0]   a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           pend_q[$];   // accepted writes not yet applied
  logic [DW-1:0] exp_q[$];    // data of every applied write, newest last
  logic [DW-1:0] m_op;
  logic [DW-1:0] m_mask;
  logic [DW-1:0] m_int;
  logic [DW-1:0] m_wr_data;
  logic [9:0]    m_en_d;
  logic [9:0]    m_en_i;
  logic          m_err;
  logic          m_irq;

  task automatic model_reset();
    pend_q.delete();
    exp_q.delete();
    m_op      = '0;
    m_mask    = '0;
    m_int     = '0;
    m_wr_data = '0;
    m_en_d    = '0;
    m_en_i    = '0;
    m_err     = 1'b0;
    m_irq     = 1'b0;
  endtask

  // Advances the model across one rising edge, using the inputs sampled there.
  task automatic model_edge();
    logic [DW-1:0] op_n;
    logic [DW-1:0] mask_n;
    logic [DW-1:0] clr;
    int            a;
    bit            protect;
    wr_t           w;
`ifdef REG_WRITE_PROTECT_EN
    protect = 1'b1;
`else
    protect = 1'b0;
`endif
    op_n   = m_op;
    mask_n = m_mask;
    clr    = '0;
    m_irq  = |(m_int & ~m_mask);
    m_en_d = '0;
    m_en_i = '0;
    m_err  = 1'b0;
    if (op_done) op_n[0] = 1'b0;
    if (pend_q.size() > 0) begin
      w = pend_q.pop_front();
      exp_q.push_back(w.d);
      m_wr_data = w.d;
      a = int'(w.a);
      if (a >= int'(BD) && a < int'(BD) + 10) begin
        m_en_d = 10'(1 << (a - int'(BD)));
      end else if (a >= int'(BI) && a < int'(BI) + 10) begin
        if (protect && m_op[0]) m_err = 1'b1;
        else                    m_en_i = 10'(1 << (a - int'(BI)));
      end else if (a == int'(BC)) begin
        op_n = w.d;
      end else if (a == int'(BC) + 1) begin
        mask_n = w.d;
      end else if (a == int'(BC) + 2) begin
        clr = w.d;
      end else begin
        m_err = 1'b1;
      end
    end
    m_op   = op_n;
    m_mask = mask_n;
    m_int  = (m_int & ~clr) | int_set;
    if (s_sel && s_wr) begin
      w.a = s_addr;
      w.d = s_din;
      pend_q.push_back(w);
    end
  endtask

  task automatic compare_all();
    check("wr_en_data", DW'(wr_en_data), DW'(m_en_d));
    check("wr_en_inst", DW'(wr_en_inst), DW'(m_en_i));
    check("wr_err",     DW'(wr_err),     DW'(m_err));
    check("wr_data",    wr_data,         m_wr_data);
    check("op_start",   op_start,        m_op);
    check("int_mask",   int_mask,        m_mask);
    check("interrupt",  interrupt,       m_int);
    check("irq",        DW'(irq),        DW'(m_irq));
    check("strobe_pending", DW'(dbg_state), DW'(pend_q.size() != 0));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Drives one cycle of inputs, then runs the model and the comparison
  // just after the rising edge.
  task automatic cycle(input bit sel, input bit wr, input logic [15:0] a,
                       input logic [DW-1:0] d, input bit done, input logic [DW-1:0] set);
    @(negedge clk);
    s_sel   = sel;
    s_wr    = wr;
    s_addr  = a;
    s_din   = d;
    op_done = done;
    int_set = set;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic write(input logic [15:0] a, input logic [DW-1:0] d);
    cycle(1'b1, 1'b1, a, d, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] ra;
    int          sel_kind;

    s_sel   = 1'b0;
    s_wr    = 1'b0;
    s_addr  = '0;
    s_din   = '0;
    op_done = 1'b0;
    int_set = '0;
    reset   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_wr_en_data", DW'(wr_en_data), '0);
    check("reset_op_start",   op_start,        '0);
    check("reset_irq",        DW'(irq),        '0);
    @(negedge clk);
    reset = 1'b0;

    // Single DATA write, strobe two cycles after it is presented.
    write(16'h0103, 64'hDEAD_BEEF);
    idle(1);
    check("r3_strobe", DW'(wr_en_data), DW'(10'b0000001000));
    check("r3_data",   wr_data,         64'hDEAD_BEEF);
    idle(1);
    check("r3_one_cycle", DW'(wr_en_data), '0);
    check("r3_data_hold", wr_data,         64'hDEAD_BEEF);

    // Back-to-back writes produce strobes on consecutive cycles.
    write(16'h0110, 64'h11);
    write(16'h0119, 64'h22);
    check("b2b_i0", DW'(wr_en_inst), DW'(10'b0000000001));
    write(16'h0109, 64'h33);
    check("b2b_i9", DW'(wr_en_inst), DW'(10'b1000000000));
    idle(1);
    check("b2b_r9", DW'(wr_en_data), DW'(10'b1000000000));
    check("b2b_data", wr_data, 64'h33);
    idle(1);

    // Illegal addresses: wr_err only, control registers untouched.
    write(16'h010A, 64'hFFFF);
    write(16'h0123, 64'hFFFF);
    check("err_010a", DW'(wr_err), 64'd1);
    idle(1);
    check("err_0123", DW'(wr_err), 64'd1);
    check("err_no_op", op_start, '0);
    idle(1);

    // Interrupt set/clear and irq.
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 64'h5);
    write(16'h0121, 64'h1);
    idle(2);
    check("int_val", interrupt, 64'h5);
    check("irq_on",  DW'(irq),  64'd1);
    write(16'h0122, 64'h4);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 64'h4);
    check("int_set_wins", interrupt, 64'h5);
    write(16'h0122, 64'h5);
    idle(1);
    check("int_cleared", interrupt, 64'h0);
    idle(1);
    check("irq_off", DW'(irq), 64'd0);

    // OP_START and instruction write protection.
    write(16'h0120, 64'h1);
    idle(1);
    check("op_start_set", op_start, 64'h1);
    write(16'h0112, 64'hABCD);
    idle(1);
`ifdef REG_WRITE_PROTECT_EN
    check("protect_err",    DW'(wr_err),     64'd1);
    check("protect_no_i2",  DW'(wr_en_inst), '0);
`else
    check("unprot_i2",      DW'(wr_en_inst), DW'(10'b0000000100));
    check("unprot_no_err",  DW'(wr_err),     64'd0);
`endif
    cycle(1'b0, 1'b0, '0, '0, 1'b1, '0);
    check("op_done_clear", DW'(op_start[0]), 64'd0);

    // Reset while a strobe is pending.
    write(16'h0105, 64'h55);
    @(negedge clk);
    s_sel = 1'b0;
    s_wr  = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_wr_en_data", DW'(wr_en_data), '0);
    check("midrst_wr_data",    wr_data,         '0);
    check("midrst_int",        interrupt,       '0);
    check("midrst_mask",       int_mask,        '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    check("postrst_no_strobe", DW'(wr_en_data), '0);

    // Randomized run.
    for (int c = 0; c < 2000; c++) begin
      sel_kind = int'($urandom_range(0, 9));
      case (sel_kind)
        0, 1, 2: ra = BD + 16'($urandom_range(0, 15));
        3, 4, 5: ra = BI + 16'($urandom_range(0, 15));
        6, 7, 8: ra = BC + 16'($urandom_range(0, 3));
        default: ra = 16'($urandom);
      endcase
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), ra,
            {$urandom, $urandom} | DW'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0) ? (DW'($urandom) & DW'($urandom) & DW'($urandom)) : '0);
    end
    idle(3);
    check("writes_applied", DW'(exp_q.size() > 0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
